// File: rtl/timer_pkg.sv
// Shared types and constants for the minutes:seconds timer control stage.
package timer_pkg;

  // Controller states; the encoding is exposed on the interface for observation.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Clock cycles per count tick: one second at 50 MHz.
  localparam int DEFAULT_CLK_DIV = 50000000;

  // BCD digit width used by the down-counter chain fed by this block.
  localparam int DIGIT_W = 4;

endpackage

// File: rtl/timer_ctrl_fsm_if.sv
// Button / counter-chain signal bundle for timer_ctrl_fsm.
//
// Signalling: there is no valid/ready pairing on this bundle. start, stop and
// load are level buttons and only their rising edges carry meaning; zero_all
// is a level status. loadn is a one-cycle active-low strobe and enable a
// one-cycle active-high strobe; both are consumed unconditionally by the
// counter chain on the clock edge that follows, so no backpressure exists.
// The state field mirrors the controller state register for observation.
interface timer_ctrl_fsm_if;
  import timer_pkg::*;

  logic   start;
  logic   stop;
  logic   load;
  logic   zero_all;
  logic   loadn;
  logic   enable;
  logic   running;
  logic   paused;
  logic   alarm;
  state_t state;

  // Button/counter side: drives the buttons and zero flag, watches the controls.
  modport master (
    output start, stop, load, zero_all,
    input  loadn, enable, running, paused, alarm, state
  );

  // Controller side.
  modport slave (
    input  start, stop, load, zero_all,
    output loadn, enable, running, paused, alarm, state
  );

endinterface

// File: rtl/tick_gen.sv
// Prescaler for the timer: counts 0..CLK_DIV-1 while run is high and flags
// the terminal count so the controller can issue one tick per second.
module tick_gen
  import timer_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV,
  parameter int PRESC_W = $clog2(CLK_DIV)
) (
  input  logic clock,
  input  logic clr,
  input  logic run,
  input  logic sync_clear,
  output logic wrap
);

  localparam logic [PRESC_W-1:0] LAST = PRESC_W'(CLK_DIV - 1);

  logic [PRESC_W-1:0] count;

  // Terminal count is only meaningful while counting; a held count never wraps.
  assign wrap = run && (count == LAST);

  // Prescaler register: clear wins over counting, and it holds while run is low.
  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      count <= '0;
    end else if (sync_clear) begin
      count <= '0;
    end else if (run) begin
      count <= wrap ? '0 : count + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/timer_ctrl_fsm.sv
// Control stage ahead of the seconds/minutes down-counter chain. Converts the
// start/stop/load buttons into the chain's loadn strobe and once-per-second
// enable tick, and stops the chain at 00:00 before any digit can wrap.
// Optional build macro: ALARM_BLINK_EN (alarm blinks in DONE instead of
// being held steady, with the prescaler kept running to time the blink).
module timer_ctrl_fsm
  import timer_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV,
  parameter int PRESC_W = $clog2(CLK_DIV)
) (
  input  logic               clock,
  input  logic               clr,
  timer_ctrl_fsm_if.slave    bus
);

  state_t state;
  state_t state_next;

  logic start_q;
  logic stop_q;
  logic load_q;
  logic start_e;
  logic stop_e;
  logic load_e;

  logic presc_run;
  logic presc_clear;
  logic wrap;

  logic loadn_r;
  logic enable_r;
  logic running_r;
  logic paused_r;
  logic alarm_r;
  logic loadn_d;
  logic enable_d;
  logic alarm_d;

  // Button history: one register per button, cleared so a button already
  // high when reset releases is seen as a fresh press.
  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      start_q <= bus.start;
      stop_q  <= bus.stop;
      load_q  <= bus.load;
    end
  end

  assign start_e = bus.start & ~start_q;
  assign stop_e  = bus.stop  & ~stop_q;
  assign load_e  = bus.load  & ~load_q;

  // The prescaler advances in RUN; with blinking it also times the alarm in DONE.
`ifdef ALARM_BLINK_EN
  assign presc_run = (state == ST_RUN) || (state == ST_DONE);
`else
  assign presc_run = (state == ST_RUN);
`endif

  // Restart the second from zero while idle and on any return to idle, so a
  // fresh start always gets a full first second.
  assign presc_clear = (state == ST_IDLE) || (state_next == ST_IDLE);

  tick_gen #(
    .CLK_DIV (CLK_DIV),
    .PRESC_W (PRESC_W)
  ) u_tick_gen (
    .clock      (clock),
    .clr        (clr),
    .run        (presc_run),
    .sync_clear (presc_clear),
    .wrap       (wrap)
  );

  // State register.
  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; load outranks stop, which outranks start.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (!load_e && start_e && !bus.zero_all) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (load_e) begin
          state_next = ST_IDLE;
        end else if (stop_e) begin
          state_next = ST_PAUSE;
        end else if (wrap && bus.zero_all) begin
          state_next = ST_DONE;
        end
      end
      ST_PAUSE: begin
        if (load_e) begin
          state_next = ST_IDLE;
        end else if (start_e) begin
          state_next = ST_RUN;
        end
      end
      ST_DONE: begin
        if (load_e || start_e || stop_e) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode: next values of the registered strobes and alarm.
  always_comb begin
    // Every load press reloads the chain, whatever state it arrives in.
    loadn_d  = ~load_e;
    // A tick only when staying in RUN across the second boundary with digits left.
    enable_d = (state == ST_RUN) && (state_next == ST_RUN) && wrap && !bus.zero_all;
`ifdef ALARM_BLINK_EN
    if (state_next != ST_DONE) begin
      alarm_d = 1'b0;
    end else if (state != ST_DONE) begin
      alarm_d = 1'b1;
    end else if (wrap) begin
      alarm_d = ~alarm_r;
    end else begin
      alarm_d = alarm_r;
    end
`else
    alarm_d = (state_next == ST_DONE);
`endif
  end

  // Output registers; reset cuts any loadn pulse short immediately.
  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      loadn_r   <= 1'b1;
      enable_r  <= 1'b0;
      running_r <= 1'b0;
      paused_r  <= 1'b0;
      alarm_r   <= 1'b0;
    end else begin
      loadn_r   <= loadn_d;
      enable_r  <= enable_d;
      running_r <= (state_next == ST_RUN);
      paused_r  <= (state_next == ST_PAUSE);
      alarm_r   <= alarm_d;
    end
  end

  assign bus.loadn   = loadn_r;
  assign bus.enable  = enable_r;
  assign bus.running = running_r;
  assign bus.paused  = paused_r;
  assign bus.alarm   = alarm_r;
  assign bus.state   = state;

  // Loading and counting in the same cycle would corrupt the chain.
  a_no_enable_with_load : assert property (
    @(posedge clock) disable iff (clr) !(enable_r && !loadn_r)
  );

  // A tick only ever leaves while the controller reports RUN.
  a_enable_only_running : assert property (
    @(posedge clock) disable iff (clr) !(enable_r && !running_r)
  );

  // Outside DONE the alarm is always quiet.
  a_alarm_only_done : assert property (
    @(posedge clock) disable iff (clr) !(alarm_r && (state != ST_DONE))
  );

endmodule

// File: tb/tb_timer_ctrl_fsm.sv
// Bench for timer_ctrl_fsm with CLK_DIV=4: directed scenarios followed by
// random button activity, all checked cycle by cycle against a timer model.
module tb_timer_ctrl_fsm;
  import timer_pkg::*;

  localparam int CLK_DIV = 4;
`ifdef ALARM_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic clock = 1'b0;
  logic clr;

  timer_ctrl_fsm_if bus ();

  timer_ctrl_fsm #(.CLK_DIV(CLK_DIV)) dut (
    .clock (clock),
    .clr   (clr),
    .bus   (bus)
  );

  // clock/reset
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: timer mode, cycles elapsed in the current second
  int   m_mode;
  int   m_ticks;
  bit   m_alarm_ph;
  bit   p_start, p_stop, p_load;
  logic e_loadn, e_enable, e_alarm;

  function automatic state_t exp_state();
    case (m_mode)
      M_RUN:   return ST_RUN;
      M_PAUSE: return ST_PAUSE;
      M_DONE:  return ST_DONE;
      default: return ST_IDLE;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_ticks = 0; m_alarm_ph = 1'b0;
    p_start = 1'b0; p_stop = 1'b0; p_load = 1'b0;
    e_loadn = 1'b1; e_enable = 1'b0; e_alarm = 1'b0;
  endtask

  task automatic model_edge(bit st, bit sp, bit ld, bit z);
    bit se, pe, le, boundary;
    se = st & ~p_start; pe = sp & ~p_stop; le = ld & ~p_load;
    p_start = st; p_stop = sp; p_load = ld;
    e_loadn = ~le;
    e_enable = 1'b0;
    boundary = 1'b0;
    // time advances during RUN (and during DONE when the alarm blinks)
    if (m_mode == M_RUN || (BLINK && m_mode == M_DONE)) begin
      boundary = (m_ticks == CLK_DIV - 1);
      m_ticks = (m_ticks + 1) % CLK_DIV;
    end
    if (le) begin
      m_mode = M_IDLE;
      m_ticks = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (se && !z) begin m_mode = M_RUN; m_ticks = 0; end
        M_RUN: begin
          if (pe) m_mode = M_PAUSE;
          else if (boundary) begin
            if (z) begin m_mode = M_DONE; m_alarm_ph = 1'b1; end
            else e_enable = 1'b1;
          end
        end
        M_PAUSE: if (se) m_mode = M_RUN;
        default: begin
          if (se || pe) begin m_mode = M_IDLE; m_ticks = 0; end
          else if (boundary) m_alarm_ph = ~m_alarm_ph;
        end
      endcase
    end
    e_alarm = (m_mode == M_DONE) && (BLINK ? m_alarm_ph : 1'b1);
  endtask

  // scoreboard
  task automatic check_bit(string tag, logic obs, logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    check_bit({tag, "/loadn"},   bus.loadn,   e_loadn);
    check_bit({tag, "/enable"},  bus.enable,  e_enable);
    check_bit({tag, "/running"}, bus.running, m_mode == M_RUN);
    check_bit({tag, "/paused"},  bus.paused,  m_mode == M_PAUSE);
    check_bit({tag, "/alarm"},   bus.alarm,   e_alarm);
    check_bit({tag, "/en_vs_loadn"}, bus.enable & ~bus.loadn, 1'b0);
    check_bit({tag, "/en_vs_zero"},  bus.enable & bus.zero_all, 1'b0);
    n_cmp++;
    assert (bus.state === exp_state()) else begin
      n_bad++;
      $error("FAIL %s/state observed=%0d expected=%0d", tag, bus.state, exp_state());
    end
  endtask

  // driver: one clock edge, advance the model, check just after the edge
  task automatic step(string tag);
    bit st, sp, ld, z, in_rst;
    st = bus.start; sp = bus.stop; ld = bus.load; z = bus.zero_all; in_rst = clr;
    @(posedge clock);
    if (in_rst) model_reset();
    else model_edge(st, sp, ld, z);
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(string tag);
    #2 clr = 1'b1;
    #1 model_reset();
    check_all(tag);
  endtask

  initial begin
    clr = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.load = 1'b0; bus.zero_all = 1'b0;
    model_reset();
    @(posedge clock); #1;
    check_all("reset");
    step("reset_hold");
    clr = 1'b0;
    step("idle_quiet");

    // load then start
    bus.load = 1'b1; step("load_edge");
    check_bit("load_pulse_low", bus.loadn, 1'b0);
    step("load_held");
    check_bit("load_pulse_one_cycle", bus.loadn, 1'b1);
    bus.load = 1'b0;
    bus.start = 1'b1; step("start_edge");
    check_bit("run_entry", bus.running, 1'b1);
    bus.start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step("run_count");
      check_bit($sformatf("enable_at_%0d", i), bus.enable, (i % 4) == 0);
    end

    // stop two cycles after an enable, then resume
    step("post_enable");
    bus.stop = 1'b1; step("stop_edge");
    check_bit("paused_on_stop", bus.paused, 1'b1);
    bus.stop = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step("pause_hold");
      check_bit("pause_no_enable", bus.enable, 1'b0);
    end
    bus.start = 1'b1; step("resume_edge");
    check_bit("resume_running", bus.running, 1'b1);
    bus.start = 1'b0; step("resume_1");
    check_bit("resume_enable_1", bus.enable, 1'b0);
    step("resume_2");
    check_bit("resume_enable_2", bus.enable, 1'b1);

    // stop and start together in RUN
    bus.start = 1'b1; bus.stop = 1'b1; step("stop_start_same");
    check_bit("stop_beats_start", bus.paused, 1'b1);
    bus.start = 1'b0; bus.stop = 1'b0; step("stop_start_release");

    // held start in PAUSE gives a single resume
    bus.start = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step("start_held");
      check_bit("held_single_resume", bus.running, 1'b1);
    end
    bus.stop = 1'b1; step("stop_after_held");
    check_bit("paused_after_held", bus.paused, 1'b1);
    bus.stop = 1'b0; bus.start = 1'b0; step("release_all");

    // asynchronous reset in RUN
    bus.start = 1'b1; step("resume_for_reset");
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) step("run_before_reset");
    async_reset("async_reset_run");
    check_bit("async_reset_running", bus.running, 1'b0);
    step("reset_hold_run");
    clr = 1'b0;

    // reset cuts a loadn pulse short; held load is a fresh edge after reset
    bus.start = 1'b1; step("run_for_load");
    bus.start = 1'b0;
    bus.load = 1'b1; step("load_in_run");
    check_bit("load_in_run_pulse", bus.loadn, 1'b0);
    async_reset("reset_during_load");
    check_bit("loadn_cut_short", bus.loadn, 1'b1);
    step("reset_hold_load");
    clr = 1'b0;
    step("load_after_reset");
    check_bit("held_button_edge_after_reset", bus.loadn, 1'b0);
    bus.load = 1'b0; step("load_release");

    // load and start together in IDLE
    bus.load = 1'b1; bus.start = 1'b1; step("load_start_same");
    check_bit("load_start_loadn", bus.loadn, 1'b0);
    check_bit("load_start_idle", bus.running, 1'b0);
    bus.load = 1'b0; bus.start = 1'b0; step("load_start_release");
    check_bit("load_start_still_idle", bus.running, 1'b0);

    // terminal zero
    bus.start = 1'b1; step("start_for_zero");
    bus.start = 1'b0;
    step("run_z1"); step("run_z2");
    bus.zero_all = 1'b1;
    for (int i = 0; i < 8 && m_mode == M_RUN; i++) begin
      step("zero_wait");
      check_bit("zero_no_enable", bus.enable, 1'b0);
    end
    check_bit("done_alarm", bus.alarm, 1'b1);
    check_bit("done_not_running", bus.running, 1'b0);
    for (int j = 1; j <= 12; j++) begin
      step("done_dwell");
      check_bit($sformatf("alarm_pattern_%0d", j), bus.alarm,
                BLINK ? ((j / 4) % 2 == 0) : 1'b1);
    end
    bus.start = 1'b1; step("done_exit");
    check_bit("done_exit_alarm", bus.alarm, 1'b0);
    bus.start = 1'b0; step("done_exit_release");
    bus.start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step("start_at_zero");
      check_bit("start_at_zero_idle", bus.running, 1'b0);
      check_bit("start_at_zero_no_enable", bus.enable, 1'b0);
    end
    bus.start = 1'b0; bus.zero_all = 1'b0; step("directed_end");

    // random button activity
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 11) == 0) bus.start = ~bus.start;
      if ($urandom_range(0, 15) == 0) bus.stop = ~bus.stop;
      if ($urandom_range(0, 39) == 0) bus.load = ~bus.load;
      if ($urandom_range(0, 59) == 0) bus.zero_all = ~bus.zero_all;
      step("random");
      if ($urandom_range(0, 499) == 0) begin
        async_reset("random_async_reset");
        step("random_reset_hold");
        clr = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/timer_ctrl_fsm.md
Name: timer_ctrl_fsm

Overview:
- Control stage directly upstream of the seconds/minutes down-counter chain in the minutes:seconds timer.
- Turns the start/stop/load buttons into the counter chain's `loadn` strobe and `enable` count tick.
- Contains a prescaler so the chain decrements once per second.
- Watches the chain's aggregate zero flag to stop at 00:00. Counters wrap 0→5 / 0→9 on enable, so this block must stop the chain before any wrap.

Parameters:
- CLK_DIV, 50000000: clock cycles per count tick (1 s); legal range ≥2.
- PRESC_W, $clog2(CLK_DIV): prescaler width, derived.

Ports:
- clock  in  1  system clock; all logic on posedge.
- clr  in  1  asynchronous active-high reset.
- start  in  1  start/resume button, synchronous level, rising-edge sensitive.
- stop  in  1  pause button, rising-edge sensitive.
- load  in  1  load-preset button, rising-edge sensitive.
- zero_all  in  1  high when every digit of the counter chain is 0.
- loadn  out  1  active-low load strobe to the counters.
- enable  out  1  one-cycle count tick to the least-significant counter.
- running  out  1  high in RUN.
- paused  out  1  high in PAUSE.
- alarm  out  1  high in DONE (see optional feature).

Behaviour:
- Reset (clr=1, asynchronous):
  - state=IDLE, prescaler=0.
  - Edge-detect history registers=0.
  - loadn=1, enable=0, running=0, paused=0, alarm=0.
- Edge detect:
  - Each button is registered once.
  - An edge at clock k means button=1 at k and 0 at k-1.
  - A button held high gives a single edge.
  - After reset, a button already high at the first clock counts as an edge.
- All outputs are registered. An action decided at edge k is visible after edge k.
- Priority for edges in the same cycle: load > stop > start.
- States: IDLE, RUN, PAUSE, DONE.
- IDLE:
  - load edge: pulse loadn=0 for exactly one cycle, stay IDLE.
  - start edge with zero_all=0: go to RUN, prescaler=0.
  - start edge with zero_all=1: ignored.
- RUN, prescaler counting:
  - Prescaler counts 0..CLK_DIV-1, then wraps to 0.
  - At the cycle it equals CLK_DIV-1, with zero_all=0: enable=1 for that one cycle.
  - At that same cycle, with zero_all=1: no enable; go to DONE.
- RUN, button edges:
  - stop edge: go to PAUSE; prescaler holds its value.
  - load edge: go to IDLE, pulse loadn=0 one cycle, prescaler=0, no enable that cycle.
- PAUSE:
  - start edge: go to RUN; prescaler resumes from its held value, giving a partial second.
  - load edge: go to IDLE with a loadn pulse.
  - stop edge: ignored.
- DONE:
  - start or stop edge: go to IDLE.
  - load edge: go to IDLE with a loadn pulse.
- Invariants:
  - enable and loadn-low are never asserted in the same cycle.
  - enable is never asserted while zero_all=1.
  - enable is only ever asserted in RUN.
- Reset mid-operation: immediate return to reset values. Any loadn pulse in progress is cut short (loadn=1).
- Decoded outputs:
  - running = (state==RUN).
  - paused = (state==PAUSE).
  - alarm per the optional feature; 0 outside DONE.

Optional Feature:
- Macro: ALARM_BLINK_EN.
- Defined:
  - In DONE the prescaler keeps counting.
  - alarm toggles at each prescaler wrap, starting high on entry to DONE (0.5 Hz blink at default).
  - alarm forced to 0 on leaving DONE.
- Undefined: alarm is steady 1 throughout DONE; prescaler is frozen in DONE.

Decomposition:
- Package timer_pkg holds:
  - state enum (IDLE, RUN, PAUSE, DONE);
  - default CLK_DIV constant;
  - digit-width constant (4) shared with the counters.
- One sub-module, tick_gen:
  - inputs: clock, clr, run, sync_clear;
  - output: wrap pulse;
  - holds the prescaler. The FSM instantiates it.

Test Plan (CLK_DIV=4):
- Reset: assert clr mid-RUN → all outputs at reset values within the same cycle; state IDLE.
- Load then start: load edge in IDLE → loadn=0 for exactly 1 cycle. start edge with zero_all=0 → running=1, and enable pulses on the 4th, 8th and 12th cycles after entry, each 1 cycle wide.
- Stop/resume: stop edge 2 cycles after an enable → paused=1, no enable for 20 cycles. start edge → next enable exactly 2 cycles after resume.
- Terminal zero: hold zero_all=1 during RUN → at the next prescaler wrap, enable stays 0 and alarm=1 (steady without ALARM_BLINK_EN; toggling every 4 cycles with it).
- Simultaneous edges: load and start rise in the same IDLE cycle → loadn pulse only, state stays IDLE. stop and start rise together in RUN → PAUSE.
- Held button: start held high for 50 cycles in PAUSE → a single resume; then stop edge → PAUSE. start edge in IDLE with zero_all=1 → stays IDLE, enable never asserted.
